proc_control_fsm: RTL and testbench



---
 rtl/proc_control_fsm.sv | 140 ++++++++++++++
 tb/tb_proc_control_fsm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/proc_control_fsm.sv
// Control unit for the simple processor datapath: fetches a 9-bit instruction
// into IR and sequences register file, A/G, adder/subtractor and bus mux over T0-T3.
module proc_control_fsm #(
    parameter int ENABLE_MVNZ = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] din,
    input  logic       g_nz,
    output logic       ir_in,
    output logic [7:0] reg_in,
    output logic [7:0] reg_out,
    output logic       din_out,
    output logic       g_out,
    output logic       a_in,
    output logic       g_in,
    output logic       add_sub,
    output logic       done,
    output logic       illegal,
    output logic [1:0] o_dbg_step,
    output logic [8:0] o_dbg_ir
);

    // run is a level request, accepted only in T0; done marks the final step,
    // so a run held high through done starts the next fetch with no idle cycle.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t      r_step;
    step_t      w_step_next;
    logic [8:0] r_ir;
    logic       w_ir_load;
    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;

    assign w_op = r_ir[8:6];
    assign w_x  = r_ir[5:3];
    assign w_y  = r_ir[2:0];

    assign o_dbg_step = r_step;
    assign o_dbg_ir   = r_ir;

    // Register X is selected by bit [7-X] of the enable vectors.
    function automatic logic [7:0] sel(input logic [2:0] idx);
        sel = 8'b1000_0000 >> idx;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_step <= T0;
            r_ir   <= 9'd0;
        end else begin
            r_step <= w_step_next;
            if (w_ir_load) begin
                r_ir <= din;
            end
        end
    end

    always_comb begin
        w_step_next = r_step;
        w_ir_load   = 1'b0;
        ir_in       = 1'b0;
        reg_in      = 8'd0;
        reg_out     = 8'd0;
        din_out     = 1'b0;
        g_out       = 1'b0;
        a_in        = 1'b0;
        g_in        = 1'b0;
        add_sub     = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (r_step)
                T0: begin
                    ir_in = run;
                    if (run) begin
                        w_ir_load   = 1'b1;
                        w_step_next = T1;
                    end
                end
                T1: begin
                    w_step_next = T0;
                    case (w_op)
                        3'b000: begin
                            reg_out = sel(w_y);
                            reg_in  = sel(w_x);
                            done    = 1'b1;
                        end
                        3'b001: begin
                            din_out = 1'b1;
                            reg_in  = sel(w_x);
                            done    = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            reg_out     = sel(w_x);
                            a_in        = 1'b1;
                            w_step_next = T2;
                        end
                        3'b100: begin
                            done = 1'b1;
                            if (ENABLE_MVNZ == 0) begin
                                illegal = 1'b1;
                            end else if (g_nz) begin
                                reg_out = sel(w_y);
                                reg_in  = sel(w_x);
                            end
                        end
                        default: begin
                            illegal = 1'b1;
                            done    = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    reg_out     = sel(w_y);
                    g_in        = 1'b1;
                    add_sub     = r_ir[6];
                    w_step_next = T3;
                end
                T3: begin
                    g_out       = 1'b1;
                    reg_in      = sel(w_x);
                    done        = 1'b1;
                    w_step_next = T0;
                end
                default: begin
                    w_step_next = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed self-checking bench for proc_control_fsm, with a second instance
// built with ENABLE_MVNZ=0 sharing the same stimulus.
module tb_proc_control_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic [8:0] din   = 9'd0;
    logic       g_nz  = 1'b0;

    logic       ir_in, din_out, g_out, a_in, g_in, add_sub, done, illegal;
    logic [7:0] reg_in, reg_out;
    logic [1:0] dbg_step;
    logic [8:0] dbg_ir;

    logic       n_ir_in, n_din_out, n_g_out, n_a_in, n_g_in, n_add_sub, n_done, n_illegal;
    logic [7:0] n_reg_in, n_reg_out;
    logic [1:0] n_dbg_step;
    logic [8:0] n_dbg_ir;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    proc_control_fsm #(.ENABLE_MVNZ(1)) dut (
        .clock(clock), .reset(reset), .run(run), .din(din), .g_nz(g_nz),
        .ir_in(ir_in), .reg_in(reg_in), .reg_out(reg_out), .din_out(din_out),
        .g_out(g_out), .a_in(a_in), .g_in(g_in), .add_sub(add_sub),
        .done(done), .illegal(illegal), .o_dbg_step(dbg_step), .o_dbg_ir(dbg_ir)
    );

    proc_control_fsm #(.ENABLE_MVNZ(0)) dut_nomvnz (
        .clock(clock), .reset(reset), .run(run), .din(din), .g_nz(g_nz),
        .ir_in(n_ir_in), .reg_in(n_reg_in), .reg_out(n_reg_out), .din_out(n_din_out),
        .g_out(n_g_out), .a_in(n_a_in), .g_in(n_g_in), .add_sub(n_add_sub),
        .done(n_done), .illegal(n_illegal), .o_dbg_step(n_dbg_step), .o_dbg_ir(n_dbg_ir)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packed output vector: {ir_in, reg_in, reg_out, din_out, g_out, a_in, g_in, add_sub, done, illegal}
    function automatic logic [31:0] ev(input logic ir, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic dout, input logic gout, input logic ain,
                                       input logic gin, input logic asub, input logic dn, input logic ill);
        ev = {8'd0, ir, rin, rout, dout, gout, ain, gin, asub, dn, ill};
    endfunction

    function automatic logic [31:0] outs_main();
        outs_main = {8'd0, ir_in, reg_in, reg_out, din_out, g_out, a_in, g_in, add_sub, done, illegal};
    endfunction

    function automatic logic [31:0] outs_nomvnz();
        outs_nomvnz = {8'd0, n_ir_in, n_reg_in, n_reg_out, n_din_out, n_g_out, n_a_in, n_g_in,
                       n_add_sub, n_done, n_illegal};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [1:0] step, input logic [31:0] exp);
        #1;
        check_eq({tag, "_step"}, {30'd0, dbg_step}, {30'd0, step});
        check_eq(tag, outs_main(), exp);
    endtask

    // Exclusivity invariants sampled mid-cycle on every clock.
    always @(negedge clock) begin
        logic [2:0] drivers;
        logic       bad;
        drivers = {|reg_out, din_out, g_out};
        bad = !$onehot0(drivers) || !$onehot0(reg_in) || !$onehot0(reg_out)
              || (done && !(dbg_step == 2'd1 || dbg_step == 2'd3));
        check_eq("invariants", {31'd0, bad}, 32'd0);
    end

    initial begin
        // Reset held with run high: ir_in must still be forced low.
        run = 1'b1;
        din = 9'b000_010_101;
        tick();
        tick();
        settle_check("reset_outs", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        check_eq("reset_ir", {23'd0, dbg_ir}, 32'd0);

        // mv R2,R5
        reset = 1'b0;
        settle_check("mv_t0", 2'd0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        run = 1'b0;
        settle_check("mv_t1", 2'd1, ev(0, 8'b0010_0000, 8'b0000_0100, 0, 0, 0, 0, 0, 1, 0));
        check_eq("mv_ir", {23'd0, dbg_ir}, {23'd0, 9'b000_010_101});
        tick();
        settle_check("mv_idle", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // mvi R0, #0x0AB
        run = 1'b1;
        din = 9'b001_000_000;
        settle_check("mvi_t0", 2'd0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        run = 1'b0;
        din = 9'h0AB;
        settle_check("mvi_t1", 2'd1, ev(0, 8'b1000_0000, 8'h00, 1, 0, 0, 0, 0, 1, 0));
        tick();
        settle_check("mvi_end", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // sub R1,R7
        run = 1'b1;
        din = 9'b011_001_111;
        tick();
        run = 1'b0;
        settle_check("sub_t1", 2'd1, ev(0, 8'h00, 8'b0100_0000, 0, 0, 1, 0, 0, 0, 0));
        tick();
        settle_check("sub_t2", 2'd2, ev(0, 8'h00, 8'b0000_0001, 0, 0, 0, 1, 1, 0, 0));
        tick();
        settle_check("sub_t3", 2'd3, ev(0, 8'b0100_0000, 8'h00, 0, 1, 0, 0, 0, 1, 0));
        tick();
        settle_check("sub_end", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // mvnz R4,R6 with g_nz=0, then g_nz=1; the ENABLE_MVNZ=0 copy flags illegal.
        run  = 1'b1;
        din  = 9'b100_100_110;
        g_nz = 1'b0;
        tick();
        run = 1'b0;
        settle_check("mvnz_z_t1", 2'd1, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0));
        check_eq("nomvnz_z_t1", outs_nomvnz(), ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        tick();
        run  = 1'b1;
        g_nz = 1'b1;
        tick();
        run = 1'b0;
        settle_check("mvnz_nz_t1", 2'd1, ev(0, 8'b0000_1000, 8'b0000_0010, 0, 0, 0, 0, 0, 1, 0));
        check_eq("nomvnz_nz_t1", outs_nomvnz(), ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        tick();
        g_nz = 1'b0;
        check_eq("nomvnz_step", {30'd0, n_dbg_step}, 32'd0);

        // Undefined opcode 110
        run = 1'b1;
        din = 9'b110_011_001;
        tick();
        run = 1'b0;
        settle_check("op110_t1", 2'd1, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        tick();
        settle_check("op110_end", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // add R3,R3 with run held high throughout, then back-to-back add R1,R2
        run = 1'b1;
        din = 9'b010_011_011;
        tick();
        settle_check("add_t1", 2'd1, ev(0, 8'h00, 8'b0001_0000, 0, 0, 1, 0, 0, 0, 0));
        tick();
        settle_check("add_t2", 2'd2, ev(0, 8'h00, 8'b0001_0000, 0, 0, 0, 1, 0, 0, 0));
        tick();
        din = 9'b010_001_010;
        settle_check("add_t3", 2'd3, ev(0, 8'b0001_0000, 8'h00, 0, 1, 0, 0, 0, 1, 0));
        tick();
        settle_check("b2b_t0", 2'd0, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        run = 1'b0;
        settle_check("add2_t1", 2'd1, ev(0, 8'h00, 8'b0100_0000, 0, 0, 1, 0, 0, 0, 0));
        tick();
        settle_check("add2_t2", 2'd2, ev(0, 8'h00, 8'b0010_0000, 0, 0, 0, 1, 0, 0, 0));

        // Reset asserted in T2 of the second add
        reset = 1'b1;
        settle_check("rst_t2", 2'd2, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        settle_check("rst_after", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        check_eq("rst_ir", {23'd0, dbg_ir}, 32'd0);
        reset = 1'b0;
        settle_check("rst_release", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        settle_check("rst_idle", 2'd0, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
